// File: rtl/fft_pkg.sv
// Shared FFT definitions: size helpers, twiddle scaling, sequencer FSM states
// and {re, im} packing helpers.
package fft_pkg;

    localparam int unsigned MAXW = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } tw_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Fixed-point unity for a W-bit twiddle component
    function automatic int tw_scale(input int w);
        return 1 << (w - 2);
    endfunction

    function automatic logic [2*MAXW-1:0] tf_pack(input logic [MAXW-1:0] re,
                                                  input logic [MAXW-1:0] im,
                                                  input int unsigned w);
        logic [2*MAXW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAXW; i++) begin
            if (i < w) begin
                r[i]     = im[i];
                r[w + i] = re[i];
            end
        end
        return r;
    endfunction

    function automatic logic [MAXW-1:0] tf_re(input logic [2*MAXW-1:0] tf,
                                              input int unsigned w);
        logic [MAXW-1:0] r;
        for (int unsigned i = 0; i < MAXW; i++)
            r[i] = (i < w) ? tf[w + i] : tf[2*w - 1];
        return r;
    endfunction

    function automatic logic [MAXW-1:0] tf_im(input logic [2*MAXW-1:0] tf,
                                              input int unsigned w);
        logic [MAXW-1:0] r;
        for (int unsigned i = 0; i < MAXW; i++)
            r[i] = (i < w) ? tf[i] : tf[w - 1];
        return r;
    endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// Quarter-wave cosine table with a registered read; maps k (and the conjugate
// flag) onto the full half-circle twiddle W_N^k.
module twiddle_qrom
    import fft_pkg::*;
#(
    parameter  int N     = 8,
    parameter  int W     = 8,
    localparam int LOG2N = clog2(N),
    localparam int KW    = LOG2N - 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            inverse,
    input  logic [KW-1:0]   k,
    output logic [2*W-1:0]  tf
);

    localparam int Q     = N / 4;
    localparam int SCALE = tw_scale(W);
    localparam logic [KW-1:0] KQ = KW'(Q);

    // Rounds half away from zero
    function automatic int cos_q(input int m);
        real v;
        v = real'(SCALE) * $cos(2.0 * 3.14159265358979323846 * real'(m) / real'(N));
        if (v >= 0.0) return $rtoi(v + 0.5);
        else          return -$rtoi(0.5 - v);
    endfunction

    logic signed [W-1:0] ctab [0:Q];

    for (genvar m = 0; m <= Q; m++) begin : g_tab
        localparam int CV = cos_q(m);
        assign ctab[m] = W'(CV);
    end

    logic [KW-1:0]       m_idx;
    logic signed [W-1:0] re_n;
    logic signed [W-1:0] im_n;

    // Second quadrant reuses the table mirrored about N/4
    always_comb begin
        m_idx = k - KQ;
        if (k < KQ) begin
            re_n = ctab[k];
            im_n = -ctab[KQ - k];
        end else begin
            re_n = -ctab[KQ - m_idx];
            im_n = -ctab[m_idx];
        end
        if (inverse) im_n = -im_n;
    end

    always_ff @(posedge clk) begin
        if (rst)
            tf <= '0;
        else if (en)
            tf <= (2*W)'(tf_pack(MAXW'(re_n), MAXW'(im_n), W));
    end

endmodule

// File: rtl/twiddle_seq_gen.sv
// Twiddle sequencer: walks every butterfly stage-major and streams W_N^k
// through a two-stage pipeline with valid/ready backpressure.
module twiddle_seq_gen
    import fft_pkg::*;
#(
    parameter  int N     = 8,
    parameter  int W     = 8,
    localparam int LOG2N = clog2(N),
    localparam int SW    = (clog2(LOG2N) < 1) ? 1 : clog2(LOG2N),
    localparam int KW    = LOG2N - 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           inverse,
    output logic           busy,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_tf,
    output logic [KW-1:0]  out_k,
    output logic [SW-1:0]  out_stage,
    output logic           out_last
);

    localparam logic [KW-1:0] JLAST = KW'(N/2 - 1);
    localparam logic [SW-1:0] SLAST = SW'(LOG2N - 1);

    tw_state_e     state, state_n;
    logic [SW-1:0] s_cnt;
    logic [KW-1:0] j_cnt;
    logic          inv_q;

    logic          adv, accept, start_ok, issue, issue_last;
    logic [KW:0]   span;
    logic [KW-1:0] k_calc;

    logic          p1_valid, p1_last;
    logic [KW-1:0] p1_k;
    logic [SW-1:0] p1_stage;

    // A stalled output beat freezes counters, index stage and ROM together
    always_comb begin
        adv        = !(out_valid && !out_ready);
        accept     = out_valid && out_ready;
        start_ok   = (state == IDLE) && start;
        issue      = (state == RUN) && adv;
        issue_last = (s_cnt == SLAST) && (j_cnt == JLAST);
        span       = (KW+1)'(1) << s_cnt;
        k_calc     = (j_cnt & KW'(span - (KW+1)'(1))) << (SW'(KW) - s_cnt);
        busy       = (state != IDLE);
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_ok)            state_n = RUN;
            RUN:     if (issue && issue_last) state_n = DRAIN;
            DRAIN:   if (accept && out_last)  state_n = IDLE;
            default:                          state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_cnt <= '0;
            j_cnt <= '0;
            inv_q <= 1'b0;
        end else if (start_ok) begin
            s_cnt <= '0;
            j_cnt <= '0;
            inv_q <= inverse;
        end else if (issue) begin
            if (j_cnt == JLAST) begin
                j_cnt <= '0;
                if (!issue_last) s_cnt <= s_cnt + SW'(1);
            end else begin
                j_cnt <= j_cnt + KW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p1_valid  <= 1'b0;
            p1_last   <= 1'b0;
            p1_k      <= '0;
            p1_stage  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_k     <= '0;
            out_stage <= '0;
        end else if (adv) begin
            p1_valid  <= (state == RUN);
            p1_last   <= issue_last;
            p1_k      <= k_calc;
            p1_stage  <= s_cnt;
            out_valid <= p1_valid;
            out_last  <= p1_valid && p1_last;
            out_k     <= p1_k;
            out_stage <= p1_stage;
        end
    end

    twiddle_qrom #(.N(N), .W(W)) u_rom (
        .clk     (clk),
        .rst     (rst),
        .en      (adv),
        .inverse (inv_q),
        .k       (p1_k),
        .tf      (out_tf)
    );

endmodule

// File: doc/twiddle_seq_gen.md
Name: twiddle_seq_gen

Overview:
- Parametrised twiddle-factor sequencer for the radix-2 FFT core. Generalises the fixed 8-point twiddle table to any power-of-two size N and sample width W.
- On start, autonomously walks every butterfly of every stage and streams the matching twiddle W_N^k, with valid/ready backpressure.
- Supports forward and inverse (conjugate) mode. Feeds the butterfly datapath directly, so the FFT control FSM no longer computes twiddle addresses.

Parameters:
- N, 8: FFT size; power of two, at least 4.
- W, 8: width of each twiddle component (signed). Scale factor is 2^(W-2), so 1.0 = 64 for W=8.
- Derived localparams: LOG2N = clog2(N); SW = max(1, clog2(LOG2N)); KW = LOG2N-1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a sequence; ignored while busy=1
- inverse  in  1  sampled on an accepted start; 1 = output conjugate twiddles
- busy  out  1  high from the accepted start until the last beat is accepted
- out_valid  out  1  out_tf, out_k, out_stage and out_last are valid
- out_ready  in  1  consumer accepts the beat when out_valid && out_ready
- out_tf  out  2W  {re[2W-1:W], im[W-1:0]}, both two's complement
- out_k  out  KW  twiddle index k, range 0..N/2-1
- out_stage  out  SW  stage number s, range 0..LOG2N-1
- out_last  out  1  high on the final beat (s=LOG2N-1, j=N/2-1)

Behaviour:
- Reset: busy, out_valid and out_last = 0; out_tf, out_k and out_stage = 0; counters = 0; latched inverse = 0.
- Reset mid-sequence aborts the run immediately. No further beats are produced.
- FSM has three states:
  - IDLE. Accepted start sets busy, clears the counters (s=0, j=0), latches inverse, and moves to RUN.
  - RUN. Issues one index per unstalled cycle through the pipeline. After issuing s=LOG2N-1, j=N/2-1, moves to DRAIN.
  - DRAIN. Waits for the last beat to be accepted, then returns to IDLE and clears busy the cycle after acceptance.
- Iteration order is stage-major: s outer (0..LOG2N-1), j inner (0..N/2-1).
  - k = (j mod 2^s) << (LOG2N-1-s).
  - Total beats = (N/2)*LOG2N; N=8 gives 12.
- Pipeline is two stages, index to ROM to output register.
  - First out_valid is asserted 2 cycles after the start-accept edge.
  - With out_ready held high, one beat per cycle and no bubbles.
- Stall rule: out_valid && !out_ready freezes the whole pipeline, the counters and the ROM enable. Outputs hold stable until accepted. No beat is lost or duplicated.
- out_valid drops the cycle after the last beat is accepted, unless a new start arrives. A new start is only accepted in IDLE.
- ROM is quarter-wave: C[m] = round(2^(W-2) * cos(2*pi*m/N)) for m = 0..N/4, rounding half away from zero. It is a synchronous read.
  - k < N/4: re = C[k], im = -C[N/4-k].
  - k >= N/4, with m = k-N/4: re = -C[N/4-m], im = -C[m].
  - When inverse=1: im is negated after lookup.
  - Negation of any table value cannot overflow, because |C| ≤ 2^(W-2).
- Boundary values: k=0 gives {2^(W-2), 0}; k=N/4 gives {0, -2^(W-2)}, or {0, +2^(W-2)} when inverse=1.

Decomposition:
- Shared package fft_pkg holds:
  - clog2 function
  - the twiddle scale constant 2^(W-2)
  - FSM state encoding (IDLE, RUN, DRAIN)
  - helper functions for packing and unpacking {re, im}
- Sub-module twiddle_qrom (parameters N, W) holds the quarter-wave cosine table. It has a synchronous read with an enable input and maps k plus inverse to {re, im}.
- The top level contains only the FSM, the counters and the stall logic.

Test Plan:
- N=8, W=8, inverse=0, out_ready=1, start pulse: 12 beats starting 2 cycles later.
  - Stage 0: k = 0,0,0,0; every tf = {64, 0}.
  - Stage 1: k = 0,2,0,2; tf alternates {64, 0} and {0, -64}.
  - Stage 2: k = 0,1,2,3; tf = {64, 0}, {45, -45}, {0, -64}, {-45, -45}.
  - out_last high only on beat 12; busy drops the next cycle.
- Backpressure: toggle out_ready randomly over a full run. Require exactly the same 12-beat sequence, and outputs stable during every stall cycle.
- inverse=1 at start, then toggle inverse mid-run: all im values are negated ({45, 45} at k=1, {0, 64} at k=2). The mid-run toggle has no effect.
- start pulsed during RUN: ignored; the beat count stays at 12.
- rst asserted after 5 beats: next cycle busy=0, out_valid=0, outputs zero. A fresh start then restarts at s=0, k=0.
- N=16, W=8: stage 3 gives k=1 → {59, -24}, k=2 → {45, -45}, k=4 → {0, -64}, k=7 → {-59, -24}. Total beats = 32.
